// File: rtl/serial_subtractor_16bit.sv
// +--------------------------------------------------------------------------+
// | serial_subtractor_16bit: multi-cycle in1 - in2, one CLA slice per cycle  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_subtractor_16bit #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             borrow_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] w_a_sl, w_b_sl, w_g, w_p, w_sum;
  logic [SLICE:0]   w_c;
  logic [WIDTH-1:0] w_out_merged;

  // Generate/propagate carry chain for the slice selected by cnt_q.
  always_comb begin
    w_a_sl = a_q[cnt_q*SLICE +: SLICE];
    w_b_sl = b_q[cnt_q*SLICE +: SLICE];
    w_g    = w_a_sl & w_b_sl;
    w_p    = w_a_sl ^ w_b_sl;
    w_c    = '0;
    w_c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
    w_sum = w_p ^ w_c[SLICE-1:0];
    w_out_merged = out_q;
    w_out_merged[cnt_q*SLICE +: SLICE] = w_sum;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = in1_i;
          b_d     = ~in2_i;
          cnt_d   = '0;
          carry_d = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        out_d   = w_out_merged;
        carry_d = w_c[SLICE];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          borrow_d = ~w_c[SLICE];
          // b holds ~in2, so "a and in2 signs differ" is "a and b signs agree".
          ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_sum[SLICE-1] != a_q[WIDTH-1]);
          zero_d   = (w_out_merged == '0);
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o     = (state_q == S_BUSY);
  assign done_o     = (state_q == S_DONE);
  assign out_o      = out_q;
  assign borrow_o   = borrow_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_16bit.sv
// Scoreboard bench for serial_subtractor_16bit: accept-rule model feeds a
// queue of expected results; a monitor checks handshake timing and results.
`default_nettype none

module tb_serial_subtractor_16bit;

  localparam int NSLICE = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] in1_i = '0;
  logic [15:0] in2_i = '0;
  logic        busy_o, done_o, borrow_o, zero_o, overflow_o;
  logic [15:0] out_o;

  serial_subtractor_16bit #(.WIDTH(16), .SLICE(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .in1_i(in1_i), .in2_i(in2_i),
    .busy_o(busy_o), .done_o(done_o), .out_o(out_o),
    .borrow_o(borrow_o), .zero_o(zero_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   free_at = 0;
  int   acc_edge = 0;
  bit   acc_valid = 1'b0;
  bit   finish_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t ref_sub(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int   sa, sb, sd;
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    r.diff   = a - b;
    r.borrow = (a < b);
    r.zero   = (r.diff == 16'h0000);
    r.ovf    = (sd > 32767) || (sd < -32768);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Acceptance model: a start seen at an edge is taken only once the previous
  // operation has fully drained (NSLICE busy cycles plus one done cycle).
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        acc_valid = 1'b0;
        free_at   = 0;
        q.delete();
      end else begin
        cyc++;
        if (start_i && cyc >= free_at) begin
          e = ref_sub(in1_i, in2_i);
          q.push_back(e);
          acc_valid = 1'b1;
          acc_edge  = cyc;
          free_at   = cyc + NSLICE + 2;
        end
      end
    end
  end

  // Monitor: owns all comparisons and the summary.
  initial begin
    exp_t e;
    bit   exp_busy, exp_done;
    while (!finish_req) begin
      @(negedge clk_i or negedge rst_ni);
      #1;
      if (!rst_ni) begin
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_out", 32'(out_o), 32'd0);
        check("rst_borrow", 32'(borrow_o), 32'd0);
        check("rst_zero", 32'(zero_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
      end else begin
        exp_busy = acc_valid && (cyc >= acc_edge) && (cyc < acc_edge + NSLICE);
        exp_done = acc_valid && (cyc == acc_edge + NSLICE);
        check("busy", 32'(busy_o), 32'(exp_busy));
        check("done", 32'(done_o), 32'(exp_done));
        if (done_o) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending op at t=%0t", $time);
          end else begin
            e = q.pop_front();
            check("out", 32'(out_o), 32'(e.diff));
            check("borrow", 32'(borrow_o), 32'(e.borrow));
            check("zero", 32'(zero_o), 32'(e.zero));
            check("overflow", 32'(overflow_o), 32'(e.ovf));
          end
        end
      end
    end
    check("pending_ops", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk_i);
    start_i = 1'b1;
    in1_i   = a;
    in2_i   = b;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (NSLICE + 2) @(negedge clk_i);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    op(16'h1234, 16'h0234);
    op(16'h0000, 16'h0001);
    op(16'h8000, 16'h0001);
    op(16'h7FFF, 16'hFFFF);
    op(16'h5A5A, 16'h5A5A);
    op(16'hFFFF, 16'h0000);

    // start held high; operands change while busy
    @(negedge clk_i);
    start_i = 1'b1;
    in1_i   = 16'h0010;
    in2_i   = 16'h0001;
    @(negedge clk_i);
    in1_i   = 16'hAAAA;
    in2_i   = 16'h5555;
    repeat (12) @(negedge clk_i);
    start_i = 1'b0;
    repeat (NSLICE + 4) @(negedge clk_i);

    // asynchronous reset in the middle of slice 2
    @(negedge clk_i);
    start_i = 1'b1;
    in1_i   = 16'h1234;
    in2_i   = 16'h0234;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    op(16'h1234, 16'h0234);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      start_i = 1'($urandom_range(0, 1));
      in1_i   = pick();
      in2_i   = pick();
    end
    start_i = 1'b0;
    repeat (NSLICE + 4) @(negedge clk_i);
    finish_req = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor_16bit.md
Name: serial_subtractor_16bit

Overview:
- Multi-cycle 16-bit subtractor: out = in1 - in2, computed as in1 + ~in2 + 1.
- Uses one SLICE-bit carry-lookahead slice per cycle, LSB slice first, with the carry held in a register between slices.
- Inverse-direction companion to the registered 16-bit CLA adder datapath; trades latency for area.
- start/busy/done handshake toward the issuing controller; registered result and flags.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSLICE = WIDTH/SLICE (4 by default).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  minuend; captured on the accepted start edge.
- in2  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high in BUSY.
- done  output  1  one-cycle pulse; result and flags are valid.
- out  output  WIDTH  difference, in1 - in2 mod 2^WIDTH.
- borrow  output  1  unsigned borrow: 1 iff in1 < in2 unsigned.
- zero  output  1  out == 0.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset: rst low asynchronously forces the following, regardless of clk:
  - state=IDLE, busy=0, done=0, out=0, borrow=0, zero=0, overflow=0.
  - Internal operand registers, slice counter and carry register cleared.
- Reset mid-operation aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Edge with start=1: latch a=in1, b=~in2; cnt=0; carry=1; state goes to BUSY.
  - busy=1 and done=0 from the next cycle.
  - out and the flags keep their previous values until the new result is written.
- BUSY, each edge:
  - Compute slice cnt as a[cnt*SLICE +: SLICE] + b[same] + carry.
  - Write the sum bits into out[cnt*SLICE +: SLICE]; carry takes the slice carry-out; cnt increments.
  - Slices are written in place; out shows partial results while busy=1. Consumers sample only on done.
- Last slice (cnt=NSLICE-1), same edge as its write:
  - borrow = ~carry_out.
  - overflow = (a[MSB] != in2_latched[MSB]) && (sum[MSB] != a[MSB]).
  - zero = (final out == 0), computed including the slice just written.
  - state goes to DONE; busy=0; done=1.
- DONE: lasts exactly one cycle; done returns to 0 and state goes to IDLE unconditionally.
- Start handling:
  - start is ignored in BUSY and DONE; it is not queued.
  - The earliest next accept is the edge after DONE.
- Latency: start accepted at edge E0; done=1 after edge E(NSLICE), i.e. E4 by default. Results are held stable until the next accepted start modifies out.
- Minimum issue interval is NSLICE+2 cycles.
- in1/in2 changing while busy has no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- Reset, then 0x1234 - 0x0234 -> done exactly 4 cycles after the start edge; out=0x1000, borrow=0, zero=0, overflow=0; busy high for 4 cycles, done high for 1.
- 0x0000 - 0x0001 -> out=0xFFFF, borrow=1, overflow=0, zero=0.
- 0x8000 - 0x0001 -> out=0x7FFF, overflow=1, borrow=0; then 0x7FFF - 0xFFFF -> out=0x8000, overflow=1, borrow=1.
- 0x5A5A - 0x5A5A -> out=0x0000, zero=1, borrow=0; second op 0xFFFF - 0x0000 -> out=0xFFFF, zero=0.
- start held high continuously with in1/in2 changed to 0xAAAA/0x5555 during BUSY -> first op 0x0010 - 0x0001 completes as out=0x000F; second op accepted on the edge after DONE using the values present then; no done pulse is lost or duplicated.
- Assert rst low asynchronously mid-cycle during slice 2 of 0x1234 - 0x0234 -> all outputs 0 immediately; no done pulse; a fresh start after release yields the correct result (out=0x1000).
